// File: rtl/fetch_if.sv
// Fetch-stage bus: hazard/branch control in, instruction memory word in,
// PC and IF/ID pipeline register contents out.
interface fetch_if;
  logic        FETCH_stall;
  logic        FETCH_redirect_valid;
  logic [31:0] FETCH_redirect_target;
  logic [31:0] FETCH_instr_in;
  logic [31:0] FETCH_PC;
  logic [31:0] FETCH_IFID_instr;
  logic [31:0] FETCH_IFID_pc4;
  logic        FETCH_IFID_valid;
  logic [31:0] FETCH_count;

  modport master (
    input  FETCH_stall, FETCH_redirect_valid, FETCH_redirect_target, FETCH_instr_in,
    output FETCH_PC, FETCH_IFID_instr, FETCH_IFID_pc4, FETCH_IFID_valid, FETCH_count
  );

  modport slave (
    output FETCH_stall, FETCH_redirect_valid, FETCH_redirect_target, FETCH_instr_in,
    input  FETCH_PC, FETCH_IFID_instr, FETCH_IFID_pc4, FETCH_IFID_valid, FETCH_count
  );
endinterface

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: owns the PC, decodes J in fetch, and loads the
// IF/ID register, honouring downstream redirect (flush) and hazard stall.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic    FETCH_clk,
  input  logic    FETCH_reset,
  fetch_if.master bus
);

  localparam logic [5:0] OP_J = 6'b000010;

  logic [31:0] pc_p0;
  logic [31:0] pc4_p0;
  logic [31:0] next_pc_p0;
  logic        is_jump_p0;

  logic [31:0] instr_p1;
  logic [31:0] pc4_p1;
  logic [31:0] count_p1;
  logic        vld_p1;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

  function automatic logic [31:0] jump_target(input logic [3:0]  region,
                                              input logic [25:0] index);
    return {region, index, 2'b00};
  endfunction

  // Stage p0: next-PC selection from the word currently returned by memory
  always_comb begin
    pc4_p0     = pc_p0 + 32'd4;
    is_jump_p0 = (bus.FETCH_instr_in[31:26] == OP_J);
    next_pc_p0 = is_jump_p0 ? jump_target(pc4_p0[31:28], bus.FETCH_instr_in[25:0])
                            : pc4_p0;
  end

  // Stage p0 -> p1: PC update and IF/ID capture
  always_ff @(posedge FETCH_clk) begin
    if (FETCH_reset) begin
      pc_p0    <= RESET_PC;
      instr_p1 <= NOP_WORD;
      pc4_p1   <= 32'd0;
      vld_p1   <= 1'b0;
      count_p1 <= 32'd0;
    end else if (bus.FETCH_redirect_valid) begin
      // A redirect flushes whatever is in the fetch slot, including a J.
      pc_p0    <= word_align(bus.FETCH_redirect_target);
      instr_p1 <= NOP_WORD;
      vld_p1   <= 1'b0;
    end else if (!bus.FETCH_stall) begin
      pc_p0    <= next_pc_p0;
      instr_p1 <= bus.FETCH_instr_in;
      pc4_p1   <= pc4_p0;
      vld_p1   <= 1'b1;
      count_p1 <= count_p1 + 32'd1;
    end
  end

  assign bus.FETCH_PC         = pc_p0;
  assign bus.FETCH_IFID_instr = instr_p1;
  assign bus.FETCH_IFID_pc4   = pc4_p1;
  assign bus.FETCH_IFID_valid = vld_p1;
  assign bus.FETCH_count      = count_p1;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a fetch-rule reference model, plus
// directed cases for sequential fetch, J decode, redirect, stall, wrap and reset.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  fetch_if bus_a ();
  fetch_if bus_b ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_WORD(NOP)) dut_a (
    .FETCH_clk(clk), .FETCH_reset(rst_a), .bus(bus_a.master)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .NOP_WORD(NOP)) dut_b (
    .FETCH_clk(clk), .FETCH_reset(rst_b), .bus(bus_b.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  bit          use_mem;
  logic [31:0] force_word;

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pc4, m_count;
  logic        m_valid;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    logic [31:0] w;
    w = (addr * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    if (w[3:0] == 4'h0) w[31:26] = 6'b000010;
    else if (w[31:26] == 6'b000010) w[31:26] = 6'b000000;
    return w;
  endfunction

  always_comb bus_a.FETCH_instr_in = use_mem ? mem_word(bus_a.FETCH_PC) : force_word;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".pc"},    bus_a.FETCH_PC,                 m_pc);
    check({tag, ".instr"}, bus_a.FETCH_IFID_instr,         m_instr);
    check({tag, ".pc4"},   bus_a.FETCH_IFID_pc4,           m_pc4);
    check({tag, ".valid"}, {31'd0, bus_a.FETCH_IFID_valid}, {31'd0, m_valid});
    check({tag, ".count"}, bus_a.FETCH_count,              m_count);
  endtask

  // Applies one cycle of inputs, advances the model by the fetch rules, then checks.
  task automatic step(input bit r, input bit s, input bit rv, input logic [31:0] rt,
                      input string tag);
    logic [31:0] w, npc4;
    rst_a = r;
    bus_a.FETCH_stall           = s;
    bus_a.FETCH_redirect_valid  = rv;
    bus_a.FETCH_redirect_target = rt;
    w = use_mem ? mem_word(m_pc) : force_word;
    if (r) begin
      m_pc = 32'h0; m_instr = NOP; m_pc4 = 32'h0; m_valid = 1'b0; m_count = 32'h0;
    end else if (rv) begin
      m_pc = (rt >> 2) * 4; m_instr = NOP; m_valid = 1'b0;
    end else if (!s) begin
      npc4 = m_pc + 32'd4;
      if (w[31:26] == 6'd2) m_pc = {npc4[31:28], w[25:0], 2'b00};
      else                  m_pc = npc4;
      m_instr = w; m_pc4 = npc4; m_valid = 1'b1; m_count = m_count + 32'd1;
    end
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  logic [31:0] saved_count;

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    use_mem = 1'b0; force_word = NOP;
    bus_a.FETCH_stall = 1'b0; bus_a.FETCH_redirect_valid = 1'b0;
    bus_a.FETCH_redirect_target = 32'h0;
    bus_b.FETCH_stall = 1'b0; bus_b.FETCH_redirect_valid = 1'b0;
    bus_b.FETCH_redirect_target = 32'h0; bus_b.FETCH_instr_in = NOP;
    m_pc = 32'hDEAD_BEEF; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_count = 32'h0;

    // Reset state
    step(1, 0, 0, 32'h0, "reset");
    check("reset.pc_const", bus_a.FETCH_PC, 32'h0);
    check("reset.cnt_const", bus_a.FETCH_count, 32'h0);
    check("wrap.reset_pc", bus_b.FETCH_PC, 32'hFFFF_FFFC);
    rst_b = 1'b0;

    // Sequential fetch A0, A1, A2
    force_word = 32'h0000_00A0;
    step(0, 0, 0, 32'h0, "seq0");
    check("seq0.pc_const", bus_a.FETCH_PC, 32'h4);
    check("seq0.instr_const", bus_a.FETCH_IFID_instr, 32'hA0);
    check("wrap.pc", bus_b.FETCH_PC, 32'h0);
    check("wrap.pc4", bus_b.FETCH_IFID_pc4, 32'h0);
    force_word = 32'h0000_00A1;
    step(0, 0, 0, 32'h0, "seq1");
    force_word = 32'h0000_00A2;
    step(0, 0, 0, 32'h0, "seq2");
    check("seq2.pc_const", bus_a.FETCH_PC, 32'hC);
    check("seq2.pc4_const", bus_a.FETCH_IFID_pc4, 32'hC);
    check("seq2.cnt_const", bus_a.FETCH_count, 32'd3);

    // J decoded in fetch
    force_word = NOP;
    step(0, 0, 1, 32'h38, "jmp_setup");
    force_word = 32'h0BFF_FFF1;
    step(0, 0, 0, 32'h0, "jmp");
    check("jmp.pc_const", bus_a.FETCH_PC, 32'h0FFF_FFC4);
    check("jmp.pc4_const", bus_a.FETCH_IFID_pc4, 32'h3C);

    // Redirect with misaligned target, J in slot is flushed
    step(0, 0, 1, 32'h30, "redir_setup");
    saved_count = bus_a.FETCH_count;
    step(0, 0, 1, 32'h1F, "redir");
    check("redir.pc_const", bus_a.FETCH_PC, 32'h1C);
    check("redir.count_held", bus_a.FETCH_count, saved_count);
    force_word = NOP;
    step(0, 0, 0, 32'h0, "redir_next");
    check("redir_next.pc_const", bus_a.FETCH_PC, 32'h20);

    // Stall hold, then stall plus redirect
    step(0, 0, 1, 32'hC, "stall_setup");
    step(0, 0, 0, 32'h0, "stall_pre");
    saved_count = bus_a.FETCH_count;
    for (int i = 0; i < 3; i++) step(0, 1, 0, 32'h0, "stall");
    check("stall.pc_const", bus_a.FETCH_PC, 32'h10);
    check("stall.count_held", bus_a.FETCH_count, saved_count);
    step(0, 1, 1, 32'h40, "stall_redir");
    check("stall_redir.pc_const", bus_a.FETCH_PC, 32'h40);

    // Mid-run reset with stall and redirect
    step(0, 0, 1, 32'h24, "mreset_setup");
    step(1, 1, 1, 32'h80, "mreset");
    check("mreset.pc_const", bus_a.FETCH_PC, 32'h0);
    check("mreset.valid_const", {31'd0, bus_a.FETCH_IFID_valid}, 32'h0);

    // Randomized stream against the model
    use_mem = 1'b1;
    step(0, 0, 0, 32'h0, "rand_start");
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 20),
           ($urandom_range(0, 99) < 10), $urandom, "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
